// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register index width, multi-cycle unit FSM
// states, the hard-wired zero register and forwarding-mux select encodings.
package pipeline_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mc_state_t;

  localparam logic [REG_AW-1:0] X0 = 5'd0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/mc_latency_counter.sv
// Down-counter for the multi-cycle unit: load to MC_LAT-1 on issue, decrement
// while the op is in flight, flag zero to signal that the next cycle is WB.
module mc_latency_counter #(
  parameter int MC_LAT = 4,
  parameter int CW     = $clog2(MC_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(MC_LAT - 1);
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. Stalls the front end on load-use, on RAW/WAW
// against registers owned by the multi-cycle unit, and on structural conflict
// with that unit; tracks the single in-flight multi-cycle op to writeback.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall-cycle counter).
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_AW-1:0]    RS1_ID,
  input  logic [REG_AW-1:0]    RS2_ID,
  input  logic                 Use_RS1_ID,
  input  logic                 Use_RS2_ID,
  input  logic [REG_AW-1:0]    RD_ID,
  input  logic                 RegWrite_ID,
  input  logic                 MultiCycle_ID,
  input  logic                 Valid_ID,
  input  logic [REG_AW-1:0]    RD_EX,
  input  logic                 MemRead_EX,
  input  logic                 Flush,
  output logic                 Stall,
  output logic                 Bubble,
  output logic                 MC_Busy,
  output logic                 MC_WB,
  output logic [REG_AW-1:0]    MC_RD,
  output logic [2**REG_AW-1:0] Pending_Mask,
  output logic [CNT_W-1:0]     Stall_Cycles
);

  localparam int MASK_W = 2**REG_AW;
  localparam int CW     = $clog2(MC_LAT + 1);
  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(X0);

  mc_state_t          state_reg;
  mc_state_t          state_next;
  logic [REG_AW-1:0]  mc_rd_reg;
  logic [MASK_W-1:0]  mask_reg;
  logic [MASK_W-1:0]  mask_next;
  logic [MASK_W-1:0]  wb_clear_vec;
  logic [MASK_W-1:0]  waw_mask;

  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CW-1:0]      cnt_value;

  logic               id_live;
  logic               load_use;
  logic               raw_hit;
  logic               waw_hit;
  logic               struct_hit;
  logic               stall_int;
  logic               issue;

  mc_latency_counter #(
    .MC_LAT (MC_LAT),
    .CW     (CW)
  ) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .count (cnt_value),
    .zero  (cnt_zero)
  );

  // Bit owned by the op that writes back this cycle; it is released at the edge.
  always_comb begin
    wb_clear_vec = '0;
    if (state_reg == WB) begin
      wb_clear_vec[mc_rd_reg] = 1'b1;
    end
  end

  // WAW ignores the register being written back right now: any new writer
  // lands strictly later, so ordering is already correct. This is what lets a
  // same-destination multi-cycle op issue back-to-back in the WB cycle.
  assign waw_mask = mask_reg & ~wb_clear_vec;

  // Hazard detection; every term is gated by a live (valid, unflushed) ID slot.
  always_comb begin
    id_live    = Valid_ID & ~Flush;
    load_use   = MemRead_EX & (RD_EX != ZERO_REG) &
                 ((Use_RS1_ID & (RS1_ID == RD_EX)) |
                  (Use_RS2_ID & (RS2_ID == RD_EX)));
    // RAW still sees the bit during WB: the result is only usable afterwards.
    raw_hit    = (Use_RS1_ID & (RS1_ID != ZERO_REG) & mask_reg[RS1_ID]) |
                 (Use_RS2_ID & (RS2_ID != ZERO_REG) & mask_reg[RS2_ID]);
    waw_hit    = RegWrite_ID & (RD_ID != ZERO_REG) & waw_mask[RD_ID];
    struct_hit = MultiCycle_ID & (state_reg == BUSY);
    stall_int  = id_live & (load_use | raw_hit | waw_hit | struct_hit);
    issue      = Valid_ID & MultiCycle_ID & ~stall_int & ~Flush;
  end

  assign Stall  = stall_int;
  assign Bubble = stall_int;

  // FSM next-state and counter control.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          state_next = BUSY;
          cnt_load   = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          state_next = WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WB: begin
        if (issue) begin
          state_next = BUSY;
          cnt_load   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ownership mask update: clear on writeback, then set on issue (set wins).
  always_comb begin
    mask_next = mask_reg & ~wb_clear_vec;
    if (issue && RegWrite_ID && (RD_ID != ZERO_REG)) begin
      mask_next[RD_ID] = 1'b1;
    end
  end

  // State, destination and mask registers; reset aborts any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mc_rd_reg <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (issue) begin
        mc_rd_reg <= RD_ID;
      end
    end
  end

  assign MC_Busy      = (state_reg == BUSY) || (state_reg == WB);
  assign MC_WB        = (state_reg == WB);
  assign MC_RD        = mc_rd_reg;
  assign Pending_Mask = mask_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_int && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign Stall_Cycles = stall_cnt_reg;
`else
  assign Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the stimulus process queues the
// expected outputs for each cycle it drives, the monitor pops and compares
// them on the falling edge of that cycle.
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  RS1_ID, RS2_ID, RD_ID, RD_EX;
  logic        Use_RS1_ID, Use_RS2_ID, RegWrite_ID, MultiCycle_ID, Valid_ID;
  logic        MemRead_EX, Flush;
  logic        Stall, Bubble, MC_Busy, MC_WB;
  logic [4:0]  MC_RD;
  logic [31:0] Pending_Mask;
  logic [31:0] Stall_Cycles;

  typedef struct {
    int          cyc;
    string       name;
    bit          stall;
    bit          busy;
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] mask;
    bit          chk_sc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   total;
  int   bad;
  bit   done;

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RS1_ID        (RS1_ID),
    .RS2_ID        (RS2_ID),
    .Use_RS1_ID    (Use_RS1_ID),
    .Use_RS2_ID    (Use_RS2_ID),
    .RD_ID         (RD_ID),
    .RegWrite_ID   (RegWrite_ID),
    .MultiCycle_ID (MultiCycle_ID),
    .Valid_ID      (Valid_ID),
    .RD_EX         (RD_EX),
    .MemRead_EX    (MemRead_EX),
    .Flush         (Flush),
    .Stall         (Stall),
    .Bubble        (Bubble),
    .MC_Busy       (MC_Busy),
    .MC_WB         (MC_WB),
    .MC_RD         (MC_RD),
    .Pending_Mask  (Pending_Mask),
    .Stall_Cycles  (Stall_Cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of ID/EX inputs, 1 time unit after the rising edge.
  task automatic step(input bit v, input bit mc, input bit rw,
                      input bit u1, input logic [4:0] r1,
                      input bit u2, input logic [4:0] r2,
                      input logic [4:0] rd, input bit mr,
                      input logic [4:0] rdex, input bit fl);
    @(posedge clk);
    #1;
    Valid_ID      = v;
    MultiCycle_ID = mc;
    RegWrite_ID   = rw;
    Use_RS1_ID    = u1;
    RS1_ID        = r1;
    Use_RS2_ID    = u2;
    RS2_ID        = r2;
    RD_ID         = rd;
    MemRead_EX    = mr;
    RD_EX         = rdex;
    Flush         = fl;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  // Queue the expected outputs for the current cycle.
  task automatic chk(input string nm, input bit st, input bit busy, input bit wb,
                     input logic [4:0] rd, input logic [31:0] mask, input bit rst_pt);
    exp_t e;
    e.cyc   = cyc;
    e.name  = nm;
    e.stall = st;
    e.busy  = busy;
    e.wb    = wb;
    e.rd    = rd;
    e.mask  = mask;
`ifdef HAZARD_PERF_CNT_EN
    e.chk_sc = rst_pt;
`else
    e.chk_sc = 1'b1;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation in the cycle it belongs to.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        total++;
        ok = (e.cyc == cyc) && (Stall === e.stall) && (Bubble === e.stall) &&
             (MC_Busy === e.busy) && (MC_WB === e.wb) && (MC_RD === e.rd) &&
             (Pending_Mask === e.mask) && (!e.chk_sc || (Stall_Cycles === 32'd0));
        if (!ok) begin
          bad++;
          $display("FAIL %s cyc=%0d/%0d got stall=%b bubble=%b busy=%b wb=%b rd=%0d mask=%h sc=%0d want stall=%b busy=%b wb=%b rd=%0d mask=%h",
                   e.name, cyc, e.cyc, Stall, Bubble, MC_Busy, MC_WB, MC_RD, Pending_Mask,
                   Stall_Cycles, e.stall, e.busy, e.wb, e.rd, e.mask);
        end else begin
          $display("check %s cyc=%0d stall=%b busy=%b wb=%b rd=%0d mask=%h",
                   e.name, cyc, Stall, MC_Busy, MC_WB, MC_RD, Pending_Mask);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no end want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0; total = 0; bad = 0; done = 0;
    rst_n = 1'b0;
    Valid_ID = 0; MultiCycle_ID = 0; RegWrite_ID = 0; Use_RS1_ID = 0; Use_RS2_ID = 0;
    RS1_ID = 0; RS2_ID = 0; RD_ID = 0; MemRead_EX = 0; RD_EX = 0; Flush = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    idle();                                                  chk("reset_state", 0, 0, 0, 5'd0, 32'h0, 1);

    // 1: load-use
    step(1, 0, 1, 1, 5'd5, 0, 5'd0, 5'd6, 1, 5'd5, 0);       chk("lu_rs1", 1, 0, 0, 5'd0, 32'h0, 0);
    step(1, 0, 1, 1, 5'd5, 0, 5'd0, 5'd6, 0, 5'd5, 0);       chk("lu_release", 0, 0, 0, 5'd0, 32'h0, 0);
    step(1, 0, 1, 1, 5'd0, 0, 5'd0, 5'd6, 1, 5'd0, 0);       chk("lu_x0", 0, 0, 0, 5'd0, 32'h0, 0);
    step(1, 0, 1, 0, 5'd0, 1, 5'd5, 5'd6, 1, 5'd5, 0);       chk("lu_rs2", 1, 0, 0, 5'd0, 32'h0, 0);
    step(1, 0, 1, 0, 5'd5, 0, 5'd0, 5'd6, 1, 5'd5, 0);       chk("lu_unused", 0, 0, 0, 5'd0, 32'h0, 0);

    // 2: MUL x7 then RAW consumer
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd7, 0, 5'd0, 0);       chk("mul7_issue", 0, 0, 0, 5'd0, 32'h0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 1, 1, 5'd7, 0, 5'd0, 5'd8, 0, 5'd0, 0);
      chk($sformatf("raw7_c%0d", i), 1, 1, (i == 5), 5'd7, 32'h80, 0);
    end
    step(1, 0, 1, 1, 5'd7, 0, 5'd0, 5'd8, 0, 5'd0, 0);       chk("raw7_issue", 0, 0, 0, 5'd7, 32'h0, 0);

    // 3: DIV x3, WAW and structural
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd3, 0, 5'd0, 0);       chk("div3_issue", 0, 0, 0, 5'd7, 32'h0, 0);
    step(1, 0, 1, 0, 5'd0, 0, 5'd0, 5'd3, 0, 5'd0, 0);       chk("waw3", 1, 1, 0, 5'd3, 32'h8, 0);
    for (int i = 2; i <= 4; i++) begin
      step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd9, 0, 5'd0, 0);
      chk($sformatf("struct_c%0d", i), 1, 1, 0, 5'd3, 32'h8, 0);
    end
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd9, 0, 5'd0, 0);       chk("mul9_in_wb", 0, 1, 1, 5'd3, 32'h8, 0);
    idle();                                                  chk("mul9_busy", 0, 1, 0, 5'd9, 32'h200, 0);
    repeat (3) idle();
    idle();                                                  chk("mul9_wb", 0, 1, 1, 5'd9, 32'h200, 0);
    idle();                                                  chk("mul9_done", 0, 0, 0, 5'd9, 32'h0, 0);

    // 4: same-register back-to-back
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd4, 0, 5'd0, 0);       chk("mul4a_issue", 0, 0, 0, 5'd9, 32'h0, 0);
    repeat (4) idle();
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd4, 0, 5'd0, 0);       chk("mul4b_in_wb", 0, 1, 1, 5'd4, 32'h10, 0);
    step(1, 0, 1, 1, 5'd4, 0, 5'd0, 5'd8, 0, 5'd0, 0);       chk("mul4b_busy_raw", 1, 1, 0, 5'd4, 32'h10, 0);
    repeat (3) idle();
    idle();                                                  chk("mul4b_wb", 0, 1, 1, 5'd4, 32'h10, 0);
    idle();                                                  chk("mul4b_done", 0, 0, 0, 5'd4, 32'h0, 0);

    // 5: flush and x0
    step(1, 1, 1, 1, 5'd5, 0, 5'd0, 5'd5, 1, 5'd5, 1);       chk("flush_lu", 0, 0, 0, 5'd4, 32'h0, 0);
    idle();                                                  chk("flush_no_issue", 0, 0, 0, 5'd4, 32'h0, 0);
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 5'd0, 0);       chk("mul0_issue", 0, 0, 0, 5'd4, 32'h0, 0);
    step(1, 0, 1, 1, 5'd0, 1, 5'd0, 5'd0, 1, 5'd0, 0);       chk("x0_no_stall", 0, 1, 0, 5'd0, 32'h0, 0);
    step(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 5'd0, 1);       chk("flush_keeps_op", 0, 1, 0, 5'd0, 32'h0, 0);
    repeat (2) idle();
    idle();                                                  chk("mul0_wb", 0, 1, 1, 5'd0, 32'h0, 0);

    // 6: reset mid-operation
    step(1, 1, 1, 0, 5'd0, 0, 5'd0, 5'd12, 0, 5'd0, 0);      chk("mul12_issue", 0, 0, 0, 5'd0, 32'h0, 0);
    idle();                                                  chk("mul12_busy", 0, 1, 0, 5'd12, 32'h1000, 0);
    idle();
    #1 rst_n = 1'b0;                                         chk("reset_mid", 0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();                                                  chk("after_reset", 0, 0, 0, 5'd0, 32'h0, 1);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
